// File: rtl/freq_pqueue_pkg.sv
// Shared constants and selection priority for the frequency-ordered priority queue.
// Selection key is {occurrence count, value}, compared as one unsigned number; slot index breaks final ties.
package freq_pqueue_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Tie-break order from most to least significant.
  typedef enum logic [1:0] {
    PRIO_COUNT = 2'd0,
    PRIO_VALUE = 2'd1,
    PRIO_INDEX = 2'd2
  } prio_e;

endpackage

// File: rtl/freq_pqueue_if.sv
// Request/response bundle of the frequency priority queue.
// master drives requests, slave (the queue) drives registered status and results.
interface freq_pqueue_if #(
  parameter int DATA_W = freq_pqueue_pkg::DEF_DATA_W,
  parameter int CNT_W  = $clog2(freq_pqueue_pkg::DEF_DEPTH + 1)
);

  logic [DATA_W-1:0] data_in;
  logic              enqueue_sig;
  logic              dequeue_sig;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic [CNT_W-1:0]  size;
  logic              full;
  logic              empty;
  logic              enq_drop;
  logic              deq_drop;

  modport master (
    output data_in, enqueue_sig, dequeue_sig,
    input  data_out, out_valid, size, full, empty, enq_drop, deq_drop
  );

  modport slave (
    input  data_in, enqueue_sig, dequeue_sig,
    output data_out, out_valid, size, full, empty, enq_drop, deq_drop
  );

endinterface

// File: rtl/freq_pqueue_pq_select.sv
// Combinational selector: picks the valid slot with the lowest occurrence count, then smallest value, then lowest index.
// Zero latency; purely a function of registered slot state.
module pq_select
  import freq_pqueue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1),
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  output logic [IDX_W-1:0]             sel_idx_o,
  output logic                         found_o
);

  logic [CNT_W-1:0]        occ [DEPTH];
  logic [CNT_W+DATA_W-1:0] best_key;
  logic [CNT_W+DATA_W-1:0] cur_key;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      occ[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (valid_i[j] && (data_i[j] == data_i[i])) begin
          occ[i] = occ[i] + CNT_W'(1);
        end
      end
    end
  end

  // Ascending scan with strict less-than keeps the lowest index on a full key tie.
  always_comb begin
    found_o   = 1'b0;
    sel_idx_o = '0;
    best_key  = '0;
    cur_key   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cur_key = {occ[i], data_i[i]};
      if (valid_i[i] && (!found_o || (cur_key < best_key))) begin
        found_o   = 1'b1;
        sel_idx_o = IDX_W'(i);
        best_key  = cur_key;
      end
    end
  end

endmodule

// File: rtl/freq_pqueue.sv
// Unordered slot store that dequeues the least-frequent value first; dequeue result registered, latency 1.
// No stall: requests that cannot be honoured are dropped and flagged with enq_drop/deq_drop for one cycle.
module freq_pqueue
  import freq_pqueue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst,
  freq_pqueue_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]             valid_q, valid_d, valid_freed;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [CNT_W-1:0]             size_q, size_d;
  logic                         full_q, full_d;
  logic                         empty_q, empty_d;
  logic [DATA_W-1:0]            data_out_q, data_out_d;
  logic                         out_valid_q, enq_drop_q, deq_drop_q;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [IDX_W-1:0] free_idx;
  logic             enq_acc, deq_acc;

  pq_select #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_select (
    .valid_i  (valid_q),
    .data_i   (mem_q),
    .sel_idx_o(sel_idx),
    .found_o  (sel_found)
  );

  always_comb begin
    deq_acc = bus.dequeue_sig && sel_found;
    enq_acc = bus.enqueue_sig && (!full_q || deq_acc);

    valid_freed = valid_q;
    if (deq_acc) begin
      valid_freed[sel_idx] = 1'b0;
    end

    // Descending scan leaves the lowest-index free slot, including one freed this cycle.
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_freed[i]) begin
        free_idx = IDX_W'(i);
      end
    end

    valid_d = valid_freed;
    if (enq_acc) begin
      valid_d[free_idx] = 1'b1;
    end

    unique case ({enq_acc, deq_acc})
      2'b10:   size_d = size_q + CNT_W'(1);
      2'b01:   size_d = size_q - CNT_W'(1);
      default: size_d = size_q;
    endcase

    full_d     = (size_d == CNT_W'(DEPTH));
    empty_d    = (size_d == '0);
    data_out_d = deq_acc ? mem_q[sel_idx] : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      size_q      <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      enq_drop_q  <= 1'b0;
      deq_drop_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      size_q      <= size_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      data_out_q  <= data_out_d;
      out_valid_q <= deq_acc;
      enq_drop_q  <= bus.enqueue_sig && !enq_acc;
      deq_drop_q  <= bus.dequeue_sig && !deq_acc;
    end
  end

  // Slot payload needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst && enq_acc) begin
      mem_q[free_idx] <= bus.data_in;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.size      = size_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.enq_drop  = enq_drop_q;
  assign bus.deq_drop  = deq_drop_q;

endmodule

// File: tb/tb_freq_pqueue.sv
// Directed self-checking bench for freq_pqueue with hand-computed expectations.
module tb_freq_pqueue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  freq_pqueue_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  freq_pqueue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // One clock with the given requests; outputs settle #1 after the edge, then requests drop.
  task automatic step(input logic enq, input logic deq, input logic [7:0] din);
    bus.enqueue_sig = enq;
    bus.dequeue_sig = deq;
    bus.data_in     = din;
    @(posedge clk);
    #1;
    bus.enqueue_sig = 1'b0;
    bus.dequeue_sig = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.size !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      failures++;
      $display("FAIL reset_status size=%0d empty=%b full=%b required 0/1/0", bus.size, bus.empty, bus.full);
    end
    checks++;
    if (bus.data_out !== 8'd0 || bus.out_valid !== 1'b0 || bus.enq_drop !== 1'b0 || bus.deq_drop !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs data_out=%0d out_valid=%b enq_drop=%b deq_drop=%b required 0/0/0/0",
               bus.data_out, bus.out_valid, bus.enq_drop, bus.deq_drop);
    end
  endtask

  task automatic test_deq_empty();
    do_reset();
    step(1'b0, 1'b1, 8'd0);
    checks++;
    if (bus.deq_drop !== 1'b1 || bus.out_valid !== 1'b0 || bus.data_out !== 8'd0) begin
      failures++;
      $display("FAIL deq_on_empty deq_drop=%b out_valid=%b data_out=%0d required 1/0/0",
               bus.deq_drop, bus.out_valid, bus.data_out);
    end
    step(1'b0, 1'b0, 8'd0);
    checks++;
    if (bus.deq_drop !== 1'b0) begin
      failures++;
      $display("FAIL deq_drop_pulse deq_drop=%b required 0", bus.deq_drop);
    end
  endtask

  task automatic test_freq_order();
    logic [7:0] ins [6] = '{8'd5, 8'd3, 8'd5, 8'd7, 8'd3, 8'd3};
    logic [7:0] exp [6] = '{8'd7, 8'd5, 8'd5, 8'd3, 8'd3, 8'd3};
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, ins[i]);
    checks++;
    if (bus.size !== 5'd6 || bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL order_fill size=%0d empty=%b required 6/0", bus.size, bus.empty);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 8'd0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== exp[i]) begin
        failures++;
        $display("FAIL order_deq%0d data_out=%0d out_valid=%b required %0d/1", i, bus.data_out, bus.out_valid, exp[i]);
      end
    end
    step(1'b0, 1'b0, 8'd0);
    checks++;
    if (bus.empty !== 1'b1 || bus.size !== 5'd0 || bus.out_valid !== 1'b0 || bus.data_out !== 8'd3) begin
      failures++;
      $display("FAIL order_drained empty=%b size=%0d out_valid=%b data_out=%0d required 1/0/0/3",
               bus.empty, bus.size, bus.out_valid, bus.data_out);
    end
  endtask

  task automatic test_full();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(16 + i));
    checks++;
    if (bus.size !== 5'd16 || bus.full !== 1'b1 || bus.enq_drop !== 1'b0) begin
      failures++;
      $display("FAIL full_fill size=%0d full=%b enq_drop=%b required 16/1/0", bus.size, bus.full, bus.enq_drop);
    end
    step(1'b1, 1'b0, 8'd9);
    checks++;
    if (bus.enq_drop !== 1'b1 || bus.size !== 5'd16 || bus.full !== 1'b1) begin
      failures++;
      $display("FAIL full_drop enq_drop=%b size=%0d full=%b required 1/16/1", bus.enq_drop, bus.size, bus.full);
    end
    step(1'b0, 1'b0, 8'd0);
    checks++;
    if (bus.enq_drop !== 1'b0) begin
      failures++;
      $display("FAIL enq_drop_pulse enq_drop=%b required 0", bus.enq_drop);
    end
    // Full queue: simultaneous enqueue and dequeue reuses the freed slot.
    step(1'b1, 1'b1, 8'hAA);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 8'd16 || bus.size !== 5'd16 || bus.full !== 1'b1 || bus.enq_drop !== 1'b0) begin
      failures++;
      $display("FAIL full_swap data_out=%0d out_valid=%b size=%0d full=%b enq_drop=%b required 16/1/16/1/0",
               bus.data_out, bus.out_valid, bus.size, bus.full, bus.enq_drop);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < DEPTH - 1) ? 8'(17 + i) : 8'hAA;
      step(1'b0, 1'b1, 8'd0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== exp) begin
        failures++;
        $display("FAIL full_drain%0d data_out=%0d out_valid=%b required %0d/1", i, bus.data_out, bus.out_valid, exp);
      end
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.size !== 5'd0 || bus.full !== 1'b0) begin
      failures++;
      $display("FAIL full_drained empty=%b size=%0d full=%b required 1/0/0", bus.empty, bus.size, bus.full);
    end
  endtask

  task automatic test_enq_deq_empty();
    do_reset();
    step(1'b1, 1'b1, 8'd4);
    checks++;
    if (bus.deq_drop !== 1'b1 || bus.size !== 5'd1 || bus.out_valid !== 1'b0 || bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL enqdeq_empty deq_drop=%b size=%0d out_valid=%b empty=%b required 1/1/0/0",
               bus.deq_drop, bus.size, bus.out_valid, bus.empty);
    end
    step(1'b0, 1'b1, 8'd0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 8'd4 || bus.size !== 5'd0 || bus.deq_drop !== 1'b0) begin
      failures++;
      $display("FAIL enqdeq_follow data_out=%0d out_valid=%b size=%0d deq_drop=%b required 4/1/0/0",
               bus.data_out, bus.out_valid, bus.size, bus.deq_drop);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 1'b0, 8'd9);
    // The same-cycle enqueued 1 would win on value, so it must not be chosen.
    step(1'b1, 1'b1, 8'd1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 8'd9 || bus.size !== 5'd1) begin
      failures++;
      $display("FAIL b2b_same_cycle data_out=%0d out_valid=%b size=%0d required 9/1/1", bus.data_out, bus.out_valid, bus.size);
    end
    step(1'b1, 1'b1, 8'd2);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 8'd1 || bus.size !== 5'd1) begin
      failures++;
      $display("FAIL b2b_second data_out=%0d out_valid=%b size=%0d required 1/1/1", bus.data_out, bus.out_valid, bus.size);
    end
    step(1'b0, 1'b1, 8'd0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 8'd2 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL b2b_last data_out=%0d out_valid=%b empty=%b required 2/1/1", bus.data_out, bus.out_valid, bus.empty);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(40 + i));
    checks++;
    if (bus.size !== 5'd8) begin
      failures++;
      $display("FAIL mid_fill size=%0d required 8", bus.size);
    end
    rst             = 1'b1;
    bus.enqueue_sig = 1'b1;
    bus.data_in     = 8'd77;
    @(posedge clk);
    #1;
    rst             = 1'b0;
    bus.enqueue_sig = 1'b0;
    checks++;
    if (bus.size !== 5'd0 || bus.empty !== 1'b1 || bus.enq_drop !== 1'b0 || bus.deq_drop !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset size=%0d empty=%b enq_drop=%b deq_drop=%b out_valid=%b required 0/1/0/0/0",
               bus.size, bus.empty, bus.enq_drop, bus.deq_drop, bus.out_valid);
    end
    step(1'b1, 1'b0, 8'd2);
    step(1'b0, 1'b1, 8'd0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== 8'd2 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL mid_after data_out=%0d out_valid=%b empty=%b required 2/1/1", bus.data_out, bus.out_valid, bus.empty);
    end
  endtask

  initial begin
    bus.data_in     = 8'd0;
    bus.enqueue_sig = 1'b0;
    bus.dequeue_sig = 1'b0;
    test_reset();
    test_deq_empty();
    test_freq_order();
    test_full();
    test_enq_deq_empty();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_pqueue.md
FREQ_PQUEUE -- requirements
Module: freq_pqueue

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning element width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning slot count (power of two, 2..64).
REQ-003 SHALL have parameter CNT_W, default $clog2(DEPTH+1), meaning width of size and occurrence counts.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 data_in  input  DATA_W  element to enqueue.
REQ-007 enqueue_sig  input  1  enqueue request, sampled each clk edge.
REQ-008 dequeue_sig  input  1  dequeue request, sampled each clk edge.
REQ-009 data_out  output  DATA_W  last dequeued element, registered.
REQ-010 out_valid  output  1  one-cycle pulse: data_out updated this cycle.
REQ-011 size  output  CNT_W  number of occupied slots, registered.
REQ-012 full / empty  output  1 each  size==DEPTH / size==0, registered.
REQ-013 enq_drop / deq_drop  output  1 each  one-cycle pulse: enqueue / dequeue request rejected.

Function
REQ-014 Storage SHALL be DEPTH slots of DATA_W data plus one valid bit each; no ordering implied by slot index.
REQ-015 Enqueue SHALL be accepted when enqueue_sig=1 and (not full, or dequeue accepted same cycle); data_in written to the lowest-index free slot (freed slot counts as free).
REQ-016 Rejected enqueue SHALL leave storage unchanged and pulse enq_drop next cycle.
REQ-017 Occurrence count of a slot SHALL be the number of valid slots holding an equal value, evaluated on pre-edge contents.
REQ-018 Dequeue SHALL be accepted when dequeue_sig=1 and not empty; the selected slot SHALL be the valid slot with lowest occurrence count, tie broken by smallest unsigned value, then lowest slot index.
REQ-019 Selection SHALL use contents before the same-cycle enqueue; a same-cycle enqueued element is never dequeued in that cycle.
REQ-020 Accepted dequeue SHALL, at the edge, load data_out with the selected value, clear its valid bit, and assert out_valid for the following cycle only (latency 1).
REQ-021 Dequeue on empty SHALL pulse deq_drop, leave data_out holding its previous value, out_valid=0.
REQ-022 Simultaneous accepted enqueue and dequeue SHALL leave size unchanged; when full, the enqueue SHALL reuse the freed slot.
REQ-023 size SHALL increment/decrement by exactly one per accepted operation, never wrap; full/empty SHALL be derived from next size and registered with it.
REQ-024 Selection logic SHALL be purely combinational from registered state; no multi-cycle search, no combinational path input->output.

Reset
REQ-025 On rst=1 at a clk edge, all valid bits SHALL clear, size=0, empty=1, full=0, data_out=0, out_valid=0, enq_drop=0, deq_drop=0.
REQ-026 rst SHALL take priority over same-cycle enqueue/dequeue; requests during reset are discarded without drop pulses.
REQ-027 Slot data contents need not be reset.

Structure
REQ-028 Package freq_pqueue_pkg SHALL hold default DATA_W/DEPTH constants and the tie-break priority order.
REQ-029 One combinational sub-module pq_select SHALL compute occurrence counts and return selected index plus found flag; the parent owns all registers.

Verification
REQ-030 Enqueue 5,3,5,7,3,3 then 6 dequeues -> data_out sequence 7,5,5,3,3,3 with out_valid each; then empty=1.
REQ-031 Enqueue 16 values, 17th enqueue of 9 -> enq_drop pulse, size stays 16, full=1; value 9 never appears on dequeue.
REQ-032 Full queue, simultaneous enqueue 0xAA and dequeue -> one element out, size 16, 0xAA later dequeued.
REQ-033 Dequeue after reset -> deq_drop pulse, out_valid=0, data_out=0.
REQ-034 Enqueue 4 and dequeue same cycle on empty queue -> deq_drop, size=1; next dequeue returns 4.
REQ-035 Assert rst with size=8 mid-stream plus enqueue_sig=1 -> size=0, empty=1, no drop pulses; subsequent enqueue/dequeue of 2 returns 2.
